// File: rtl/ped_request_ctrl.sv
// ============================================================================
// ped_request_ctrl
// ----------------------------------------------------------------------------
// Pedestrian crossing request controller. Conditions a raw push-button
// (synchronise + debounce), turns accepted presses into a level request to the
// light controller, runs the walk phase once the light controller grants it,
// and then enforces a cool-down lockout. Presses that arrive while walking or
// cooling down are remembered and re-raise the request once cool-down ends.
//
// All timing is counted in i_tick cycles; i_tick is a one-cycle enable from a
// shared time base.
//
// Parameters
//   DEB_TICKS   ticks a changed button level must hold before it is accepted
//   WALK_TICKS  ticks the walk lamp stays on
//   COOL_TICKS  ticks of lockout after the walk lamp goes off
//   (all three are legal in the range 1..15)
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous reset, active high
//   i_btn_raw    asynchronous push-button, active high
//   i_tick       one-cycle time-base enable
//   i_grant      one-cycle pulse: crossing phase is safe, request served
//   o_adv_req    level request to the light controller's advance input
//   o_walk       walk lamp enable
//   o_walk_cnt   remaining walk ticks, zero outside WALK
//   o_state      current state: IDLE=0, PENDING=1, WALK=2, COOL=3
//   o_press_cnt  accepted press events, saturating at 255
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// ============================================================================
module ped_request_ctrl #(
    parameter int DEB_TICKS  = 4,
    parameter int WALK_TICKS = 8,
    parameter int COOL_TICKS = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_raw,
    input  logic       i_tick,
    input  logic       i_grant,
    output logic       o_adv_req,
    output logic       o_walk,
    output logic [3:0] o_walk_cnt,
    output logic [1:0] o_state,
    output logic [7:0] o_press_cnt
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_WALK    = 2'd2,
        ST_COOL    = 2'd3
    } state_t;

    localparam logic [3:0] DEB_T  = 4'(DEB_TICKS);
    localparam logic [3:0] WALK_T = 4'(WALK_TICKS);
    localparam logic [3:0] COOL_T = 4'(COOL_TICKS);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic       r_btn_db;
    logic       r_btn_db_d;
    logic [3:0] r_deb_cnt;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_walk_cnt;
    logic [3:0] r_cool_cnt;
    logic       r_deferred;
    logic [7:0] r_press_cnt;

    logic       w_btn_s;
    logic       w_press;
    logic       w_grant_take;
    logic       w_walk_done;
    logic       w_cool_done;

    // ------------------------------------------------------------------------
    // Button synchroniser
    // ------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments, so all
    // registers sample their inputs from the same edge and the order of the
    // statements (or of the processes) never changes the result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2;

    // ------------------------------------------------------------------------
    // Debouncer
    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement (a bounce back) restarts the qualification.
    // On the tick that would bring the count to DEB_TICKS the new level is
    // accepted and the counter restarts from zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_db  <= 1'b0;
            r_deb_cnt <= 4'd0;
        end else if (w_btn_s == r_btn_db) begin
            r_deb_cnt <= 4'd0;
        end else if (i_tick) begin
            if (r_deb_cnt + 4'd1 == DEB_T) begin
                r_btn_db  <= ~r_btn_db;
                r_deb_cnt <= 4'd0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 4'd1;
            end
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_db_d <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
        end
    end

    // Press event: high for the one cycle after the debounced level rises.
    // Built only from registers; releases produce nothing.
    assign w_press = r_btn_db & ~r_btn_db_d;

    // ------------------------------------------------------------------------
    // Press counter (counts in every state, sticks at 255)
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_press_cnt <= 8'd0;
        end else if (w_press && (r_press_cnt != 8'hFF)) begin
            r_press_cnt <= r_press_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Qualified FSM events
    // ------------------------------------------------------------------------
    // Grant only matters while a request is outstanding; it needs no tick.
    assign w_grant_take = (r_state == ST_PENDING) && i_grant;
    assign w_walk_done  = (r_state == ST_WALK) && i_tick && (r_walk_cnt == 4'd1);
    assign w_cool_done  = (r_state == ST_COOL) && i_tick && (r_cool_cnt == 4'd1);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: the next state gets a default before the case statement, so every
    // path through this block assigns it and no latch can be inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Further presses are only counted; the request is already up.
                if (w_grant_take) begin
                    w_state_next = ST_WALK;
                end
            end
            ST_WALK: begin
                if (w_walk_done) begin
                    w_state_next = ST_COOL;
                end
            end
            ST_COOL: begin
                // A press landing on the final cool tick has not reached the
                // deferred flag yet, so it is folded in here directly.
                if (w_cool_done) begin
                    w_state_next = (r_deferred || w_press) ? ST_PENDING : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode (purely from the state register)
    // ------------------------------------------------------------------------
    always_comb begin
        o_adv_req = 1'b0;
        o_walk    = 1'b0;
        case (r_state)
            ST_PENDING: o_adv_req = 1'b1;
            ST_WALK:    o_walk    = 1'b1;
            default: begin
                o_adv_req = 1'b0;
                o_walk    = 1'b0;
            end
        endcase
    end

    assign o_state     = r_state;
    assign o_walk_cnt  = r_walk_cnt;
    assign o_press_cnt = r_press_cnt;

    // ------------------------------------------------------------------------
    // Walk counter
    // Loaded on grant (a coincident tick does not decrement it), counts down
    // on ticks in WALK, and is held at zero in every other state.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_walk_cnt <= 4'd0;
        end else if (w_grant_take) begin
            r_walk_cnt <= WALK_T;
        end else if (r_state == ST_WALK) begin
            if (i_tick) begin
                r_walk_cnt <= r_walk_cnt - 4'd1;
            end
        end else begin
            r_walk_cnt <= 4'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Cool-down counter
    // Loaded on the final walk tick, counts down on ticks in COOL, zero
    // elsewhere.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cool_cnt <= 4'd0;
        end else if (w_walk_done) begin
            r_cool_cnt <= COOL_T;
        end else if (r_state == ST_COOL) begin
            if (i_tick) begin
                r_cool_cnt <= r_cool_cnt - 4'd1;
            end
        end else begin
            r_cool_cnt <= 4'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Deferred-request flag
    // Remembers a press made while walking or cooling down. It is consumed
    // (cleared) when cool-down ends, whichever state follows.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deferred <= 1'b0;
        end else if (w_cool_done) begin
            r_deferred <= 1'b0;
        end else if ((r_state == ST_WALK) || (r_state == ST_COOL)) begin
            if (w_press) begin
                r_deferred <= 1'b1;
            end
        end else begin
            r_deferred <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// ============================================================================
// tb_ped_request_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for ped_request_ctrl with default parameters
// (DEB_TICKS=4, WALK_TICKS=8, COOL_TICKS=6).
//
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// well away from the next edge. A "period" is four clocks with i_tick (and
// optionally i_grant) high for the first clock only; the main vector table
// steps one period per entry and checks all outputs at its end. Multi-cycle
// corner cases follow as hand-written sequences.
// ============================================================================
module tb_ped_request_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       tick;
    logic       grant;
    logic       adv_req;
    logic       walk;
    logic [3:0] walk_cnt;
    logic [1:0] state;
    logic [7:0] press_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ped_request_ctrl #(
        .DEB_TICKS (4),
        .WALK_TICKS(8),
        .COOL_TICKS(6)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_raw  (btn_raw),
        .i_tick     (tick),
        .i_grant    (grant),
        .o_adv_req  (adv_req),
        .o_walk     (walk),
        .o_walk_cnt (walk_cnt),
        .o_state    (state),
        .o_press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic       btn;
        logic       tck;
        logic       gnt;
        logic [1:0] st;
        logic       adv;
        logic       wlk;
        logic [3:0] wc;
        logic [7:0] pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic b, input logic t, input logic g,
                       input logic [1:0] s, input logic a, input logic w,
                       input logic [3:0] wc, input logic [7:0] pc);
        vec_t v;
        v.btn = b; v.tck = t; v.gnt = g;
        v.st = s;  v.adv = a; v.wlk = w; v.wc = wc; v.pc = pc;
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int s, input int a,
                             input int w, input int wc, input int pc);
        check($sformatf("%s.state", tag),     int'(state),     s);
        check($sformatf("%s.adv_req", tag),   int'(adv_req),   a);
        check($sformatf("%s.walk", tag),      int'(walk),      w);
        check($sformatf("%s.walk_cnt", tag),  int'(walk_cnt),  wc);
        check($sformatf("%s.press_cnt", tag), int'(press_cnt), pc);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic period(input logic b, input logic t, input logic g);
        btn_raw = b;
        tick    = t;
        grant   = g;
        cyc();
        tick  = 1'b0;
        grant = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic run_ticks(input int n, input logic b);
        for (int i = 0; i < n; i++) period(b, 1'b1, 1'b0);
    endtask

    task automatic grant_only();
        grant = 1'b1;
        cyc();
        grant = 1'b0;
    endtask

    // One full press/release with tick every clock: rise accepted after
    // 2 sync + 4 ticks, event one cycle later; eight clocks per phase.
    task automatic press_fast();
        btn_raw = 1'b1;
        repeat (8) cyc();
        btn_raw = 1'b0;
        repeat (8) cyc();
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        btn_raw = 1'b0;
        tick    = 1'b0;
        grant   = 1'b0;
        repeat (3) cyc();
        check_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // ---- table: btn tick grant | state adv walk walk_cnt press_cnt ----
        add(0, 1, 1, 0, 0, 0, 0, 0);           // grant in IDLE ignored
        add(0, 1, 0, 0, 0, 0, 0, 0);
        // glitch: high for 3 ticks, never qualifies
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        // real press held 6 ticks: sync period, then 4 ticks to accept
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0, 1);           // accepted -> PENDING
        add(1, 1, 0, 1, 1, 0, 0, 1);
        // release debounces without an event, request stays up
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 1, 0, 0, 1);
        // grant together with tick: loads 8 with no decrement
        add(0, 1, 1, 2, 0, 1, 8, 1);
        // walk countdown 7..1
        for (int i = 7; i >= 1; i--) add(0, 1, 0, 2, 0, 1, 4'(i), 1);
        add(0, 1, 0, 3, 0, 0, 0, 1);           // 8th tick -> COOL
        for (int i = 0; i < 5; i++) add(0, 1, 0, 3, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1);           // 6th cool tick -> IDLE
        add(0, 1, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            period(vecs[i].btn, vecs[i].tck, vecs[i].gnt);
            check_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].adv),
                      int'(vecs[i].wlk), int'(vecs[i].wc), int'(vecs[i].pc));
        end

        // ---- deferred press during WALK, grant without tick ----
        run_ticks(5, 1'b1);
        check_all("def.req", 1, 1, 0, 0, 2);
        run_ticks(5, 1'b0);
        grant_only();
        check_all("def.grant", 2, 0, 1, 8, 2);
        run_ticks(5, 1'b1);                    // press accepted while walking
        check_all("def.walk", 2, 0, 1, 3, 3);
        run_ticks(3, 1'b0);
        check_all("def.cool", 3, 0, 0, 0, 3);
        run_ticks(5, 1'b0);
        check_all("def.cool5", 3, 0, 0, 0, 3);
        run_ticks(1, 1'b0);
        check_all("def.end", 1, 1, 0, 0, 3);

        // ---- press event on the same cycle as the final cool tick ----
        grant_only();
        run_ticks(8, 1'b0);
        check_all("last.cool", 3, 0, 0, 0, 3);
        run_ticks(4, 1'b1);                    // debounce count now 3, cool 2
        btn_raw = 1'b1;
        tick    = 1'b1;
        cyc();                                 // debounced level rises, cool 1
        check_all("last.t13", 3, 0, 0, 0, 3);
        cyc();                                 // final cool tick + press event
        tick = 1'b0;
        check_all("last.t14", 1, 1, 0, 0, 4);
        run_ticks(6, 1'b0);

        // ---- press counter saturation: 300 presses in total ----
        tick = 1'b1;
        for (int i = 0; i < 250; i++) press_fast();
        check("sat.254", int'(press_cnt), 254);
        for (int i = 0; i < 46; i++) press_fast();
        check("sat.255", int'(press_cnt), 255);
        tick = 1'b0;
        check("sat.state", int'(state), 1);

        // ---- reset in the middle of WALK ----
        grant_only();
        run_ticks(5, 1'b0);
        check("rst.wc3", int'(walk_cnt), 3);
        rst = 1'b1;
        cyc();
        check_all("rst.walk", 0, 0, 0, 0, 0);

        // ---- button held through reset: event after 2 sync + 4 ticks ----
        btn_raw = 1'b1;
        repeat (2) cyc();
        rst  = 1'b0;
        tick = 1'b1;
        repeat (6) cyc();
        check_all("held.pre", 0, 0, 0, 0, 0);
        cyc();
        check_all("held.evt", 1, 1, 0, 0, 1);
        tick    = 1'b0;
        btn_raw = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ped_request_ctrl.md
PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 Parameter DEB_TICKS, default 4: consecutive ticks a changed synchronized button level must hold before it is accepted; legal range 1..15.
REQ-002 Parameter WALK_TICKS, default 8: ticks walk is held asserted; legal range 1..15.
REQ-003 Parameter COOL_TICKS, default 6: ticks of post-walk lockout; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_raw  input  1  asynchronous pedestrian push-button, active-high.
REQ-007 tick  input  1  one-cycle time-base enable; all timing counts tick cycles.
REQ-008 grant  input  1  one-cycle pulse from the light controller: crossing phase safe, request served.
REQ-009 adv_req  output  1  level request to the light controller's advance input.
REQ-010 walk  output  1  walk lamp enable.
REQ-011 walk_cnt  output  4  remaining walk ticks; zero outside WALK.
REQ-012 state_o  output  2  current state encoding: IDLE=0, PENDING=1, WALK=2, COOL=3.
REQ-013 press_cnt  output  8  accepted press events, saturating at 255.

Function
REQ-014 btn_raw SHALL pass through a two-flop synchronizer, giving btn_s.
REQ-015 Debounce counter SHALL clear whenever btn_s equals the debounced level btn_db, and SHALL increment on tick while they differ.
REQ-016 btn_db SHALL toggle, and the debounce counter SHALL clear, on the tick at which the counter would reach DEB_TICKS.
REQ-017 A press event SHALL be a one-cycle pulse on the cycle after btn_db rises 0->1; a btn_db fall SHALL generate no event.
REQ-018 press_cnt SHALL increment on every press event in any state, holding at 255.
REQ-019 IDLE: adv_req=0, walk=0; a press event SHALL move to PENDING on the next cycle.
REQ-020 PENDING: adv_req=1; grant SHALL move to WALK and load walk_cnt=WALK_TICKS in the same edge.
REQ-021 Press events in PENDING SHALL be ignored, apart from press_cnt.
REQ-022 WALK: walk=1, adv_req=0; each tick SHALL decrement walk_cnt.
REQ-023 A tick with walk_cnt==1 SHALL clear walk_cnt, move to COOL and load the cool counter with COOL_TICKS.
REQ-024 A press event in WALK or COOL SHALL set the deferred flag; repeat presses leave it set.
REQ-025 COOL: walk=0, adv_req=0; each tick SHALL decrement the cool counter.
REQ-026 A tick with cool count==1 SHALL leave COOL and clear the deferred flag: to PENDING if the flag was set, otherwise to IDLE.
REQ-027 A press event in the same cycle as the final COOL tick SHALL count as deferred and go to PENDING.
REQ-028 grant outside PENDING SHALL be ignored.
REQ-029 grant and tick together in PENDING: grant wins; walk_cnt loads WALK_TICKS without a decrement.
REQ-030 tick is not needed for the PENDING->WALK transition; grant alone suffices.
REQ-031 An illegal state encoding SHALL recover to IDLE on the next cycle with all outputs deasserted.
REQ-032 All outputs SHALL be registered or decoded purely from registered state; no combinational path from btn_raw, tick or grant to any output.

Reset
REQ-033 While rst=1 at a clock edge, the following SHALL clear to 0 and state SHALL be IDLE: synchronizer flops, btn_db, debounce counter, walk_cnt, cool counter, deferred flag, press_cnt.
REQ-034 Reset asserted mid-WALK or mid-COOL SHALL abort immediately: walk=0 and adv_req=0 from the first reset cycle on.
REQ-035 After reset deasserts, a button already held high SHALL produce a press event after synchronizing plus DEB_TICKS ticks.

Verification
REQ-036 Glitch: btn_raw high for 3 ticks then low, tick every 4 clk -> no press event, state stays IDLE, press_cnt=0.
REQ-037 Press and grant: btn_raw held high for 6 ticks -> adv_req=1 after 4 ticks; grant pulse -> walk=1, walk_cnt=8.
REQ-038 Walk countdown: walk_cnt reaches 0 after 8 ticks, then COOL; state returns to IDLE 6 ticks later.
REQ-039 Deferred press: press during WALK -> after COOL ends, state=PENDING and adv_req=1 with no new press.
REQ-040 Corner cases: grant while in IDLE -> ignored; grant+tick together in PENDING -> walk_cnt=8; 300 presses -> press_cnt=255.
REQ-041 Reset at walk_cnt=3 -> next cycle state=IDLE, walk=0, walk_cnt=0, press_cnt=0.
